uart_rx: RTL and testbench

Oversampling UART receiver, the receive-side companion of the team's uart_tx.
- Synchronises the asynchronous serial line and detects start bits.
- Samples each bit at its centre and assembles N_DATA_BITS of data, LSB first.
- Checks the stop bit and presents each byte through a valid/ready handshake, with framing-error and overrun flags.
- Sits between the pad-level RX pin and the consumer logic (FIFO or register bank). Sample timing comes from an external oversample strobe on i_uart_en.

---
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchroniser, mid-bit sampling FSM,
// and a valid/ready output register with framing-error and overrun pulses.
module uart_rx #(
  parameter int N_DATA_BITS = 8,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                   i_uart_clk,
  input  logic                   i_uart_reset,
  input  logic                   i_uart_en,
  input  logic                   i_uart_rx,
  input  logic                   i_uart_ready,
  output logic [N_DATA_BITS-1:0] o_uart_data,
  output logic                   o_uart_data_valid,
  output logic                   o_uart_frame_err,
  output logic                   o_uart_overrun,
  output logic                   o_uart_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N_DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t                   r_state;
  logic [TW-1:0]            r_tick;
  logic [BW-1:0]            r_bit;
  logic [N_DATA_BITS-1:0]   r_shift;
  logic                     r_rx_meta;
  logic                     r_rx_s;

  state_t                   w_state_nxt;
  logic [TW-1:0]            w_tick_nxt;
  logic [BW-1:0]            w_bit_nxt;
  logic [N_DATA_BITS-1:0]   w_shift_nxt;
  logic                     w_load;
  logic                     w_ferr;

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    if (i_uart_en) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          // Half a bit in: a still-low line is a real start, otherwise a glitch.
          if (r_tick == TICK_HALF) begin
            w_tick_nxt = '0;
            if (!r_rx_s) begin
              w_state_nxt = S_DATA;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
        S_DATA: begin
          if (r_tick == TICK_LAST) begin
            w_shift_nxt[r_bit] = r_rx_s;
            w_tick_nxt         = '0;
            if (r_bit == BIT_LAST) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bit_nxt = r_bit + 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
        S_STOP: begin
          if (r_tick == TICK_LAST) begin
            w_tick_nxt = '0;
            if (r_rx_s) begin
              w_load      = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_ferr      = 1'b1;
              w_state_nxt = S_WAIT_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          // Holding here until the line rises keeps a break to a single error.
          if (r_rx_s) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_uart_clk) begin
    if (!i_uart_reset) begin
      r_rx_meta         <= 1'b1;
      r_rx_s            <= 1'b1;
      r_state           <= S_IDLE;
      r_tick            <= '0;
      r_bit             <= '0;
      r_shift           <= '0;
      o_uart_data       <= '0;
      o_uart_data_valid <= 1'b0;
      o_uart_frame_err  <= 1'b0;
      o_uart_overrun    <= 1'b0;
    end else begin
      r_rx_meta        <= i_uart_rx;
      r_rx_s           <= r_rx_meta;
      r_state          <= w_state_nxt;
      r_tick           <= w_tick_nxt;
      r_bit            <= w_bit_nxt;
      r_shift          <= w_shift_nxt;
      o_uart_frame_err <= w_ferr;
      o_uart_overrun   <= w_load & o_uart_data_valid & ~i_uart_ready;
      if (w_load) begin
        o_uart_data       <= r_shift;
        o_uart_data_valid <= 1'b1;
      end else if (i_uart_ready) begin
        o_uart_data_valid <= 1'b0;
      end
    end
  end

  assign o_uart_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framed bytes, back-to-back overrun, framing error,
// break, glitch rejection and mid-frame reset at two oversample strobe rates.
module tb_uart_rx;

  localparam int NB = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en;
  logic          rx = 1'b1;
  logic          ready = 1'b0;
  logic [NB-1:0] data;
  logic          valid;
  logic          ferr;
  logic          ovr;
  logic          busy;

  int cyc = 0;
  int en_div = 1;
  int checks = 0;
  int failures = 0;
  int n_rise = 0;
  int n_vcyc = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int last_rise = 0;
  logic prev_valid = 1'b0;
  int t_start = 0;
  int s_rise, s_vcyc, s_ferr, s_ovr;
  int e_edge, g_edge;

  uart_rx #(.N_DATA_BITS(NB), .OVERSAMPLE(OS)) dut (
    .i_uart_clk        (clk),
    .i_uart_reset      (rst_n),
    .i_uart_en         (en),
    .i_uart_rx         (rx),
    .i_uart_ready      (ready),
    .o_uart_data       (data),
    .o_uart_data_valid (valid),
    .o_uart_frame_err  (ferr),
    .o_uart_overrun    (ovr),
    .o_uart_busy       (busy)
  );

  always #5 clk = ~clk;

  // cyc equals the number of rising edges seen; en at edge n depends on n-1.
  always @(posedge clk) cyc <= cyc + 1;
  assign en = (en_div == 1) || ((cyc % en_div) == 0);

  always @(negedge clk) begin
    if (valid && !prev_valid) begin
      n_rise    <= n_rise + 1;
      last_rise <= cyc;
    end
    n_vcyc     <= n_vcyc + int'(valid);
    n_ferr     <= n_ferr + int'(ferr);
    n_ovr      <= n_ovr + int'(ovr);
    prev_valid <= valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_bit();
    tick(OS * en_div);
  endtask

  // Caller is always aligned at #1 after an edge; the next edge is the first to see the start bit.
  task automatic send(input logic [NB-1:0] d, input logic stop_b);
    rx = 1'b0;
    t_start = cyc + 1;
    wait_bit();
    for (int i = 0; i < NB; i++) begin
      rx = d[i];
      wait_bit();
    end
    rx = stop_b;
    wait_bit();
    rx = 1'b1;
  endtask

  // Two synchroniser edges, then the first strobed edge is T0; stop is sampled 152 strobes later.
  function automatic int exp_rise(input int c);
    int t0;
    t0 = c + 2;
    while (en_div != 1 && ((t0 - 1) % en_div) != 0) t0++;
    return t0 + (OS / 2 + (NB + 1) * OS) * en_div;
  endfunction

  task automatic snap();
    s_rise = n_rise;
    s_vcyc = n_vcyc;
    s_ferr = n_ferr;
    s_ovr  = n_ovr;
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(ferr), 32'h0);
    check("rst_ovr", 32'(ovr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick(4);

    // 1: single frame 0x55, ready high
    ready = 1'b1;
    snap();
    send(8'h55, 1'b1);
    tick(2);
    check("t1_data", 32'(data), 32'h55);
    check("t1_rises", n_rise - s_rise, 1);
    check("t1_latency", last_rise, exp_rise(t_start));
    check("t1_valid_cycles", n_vcyc - s_vcyc, 1);
    check("t1_flags", (n_ferr - s_ferr) + (n_ovr - s_ovr), 0);

    // 2: back-to-back 0xA3, 0x0F with ready low -> overrun
    ready = 1'b0;
    snap();
    send(8'hA3, 1'b1);
    check("t2_first_data", 32'(data), 32'hA3);
    check("t2_first_valid", 32'(valid), 32'h1);
    send(8'h0F, 1'b1);
    tick(2);
    check("t2_data", 32'(data), 32'h0F);
    check("t2_valid_held", 32'(valid), 32'h1);
    check("t2_overrun_cycles", n_ovr - s_ovr, 1);
    check("t2_rises", n_rise - s_rise, 1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("t2_valid_cleared", 32'(valid), 32'h0);
    tick(1);
    check("t2_valid_stays_clear", 32'(valid), 32'h0);

    // 3: framing error on 0x81, then good 0x3C
    ready = 1'b1;
    snap();
    send(8'h81, 1'b0);
    tick(4);
    check("t3_ferr_cycles", n_ferr - s_ferr, 1);
    check("t3_no_valid", n_rise - s_rise, 0);
    check("t3_data_kept", 32'(data), 32'h0F);
    check("t3_busy_idle", 32'(busy), 32'h0);
    snap();
    send(8'h3C, 1'b1);
    tick(2);
    check("t3_good_data", 32'(data), 32'h3C);
    check("t3_good_rises", n_rise - s_rise, 1);
    check("t3_good_latency", last_rise, exp_rise(t_start));

    // 4: break (40 bit periods low)
    tick(8);
    snap();
    rx = 1'b0;
    tick(40 * OS);
    check("t4_busy_low", 32'(busy), 32'h1);
    rx = 1'b1;
    e_edge = cyc;
    tick(2);
    check("t4_busy_before_idle", 32'(busy), 32'h1);
    tick(1);
    check("t4_busy_idle_edge", cyc, e_edge + 3);
    check("t4_busy_after", 32'(busy), 32'h0);
    tick(2);
    check("t4_ferr_once", n_ferr - s_ferr, 1);
    check("t4_no_valid", n_rise - s_rise, 0);

    // 5: 4-clock glitch, then 0xFF
    tick(8);
    snap();
    rx = 1'b0;
    g_edge = cyc + 1;
    tick(4);
    rx = 1'b1;
    tick(2);
    check("t5_busy_in_start", 32'(busy), 32'h1);
    tick(7);
    check("t5_edge", cyc, g_edge + 12);
    check("t5_busy_aborted", 32'(busy), 32'h0);
    check("t5_no_out", (n_rise - s_rise) + (n_ferr - s_ferr) + (n_ovr - s_ovr), 0);
    tick(16);
    send(8'hFF, 1'b1);
    tick(2);
    check("t5_data", 32'(data), 32'hFF);
    check("t5_rises", n_rise - s_rise, 1);
    check("t5_latency", last_rise, exp_rise(t_start));

    // 6: reset during DATA bit 3, at en every clock and then every 4th clock
    for (int div = 1; div <= 4; div += 3) begin
      en_div = div;
      tick(8);
      snap();
      fork
        send(8'hF0, 1'b1);
        begin
          tick(68 * div);
          rst_n = 1'b0;
          tick(1);
          check("t6_rst_data", 32'(data), 32'h0);
          check("t6_rst_valid", 32'(valid), 32'h0);
          check("t6_rst_busy", 32'(busy), 32'h0);
          check("t6_rst_flags", 32'({ferr, ovr}), 32'h0);
          tick(16 * div - 1);
          rst_n = 1'b1;
        end
      join
      tick(4);
      check("t6_aborted_no_out", (n_rise - s_rise) + (n_ferr - s_ferr) + (n_ovr - s_ovr), 0);
      snap();
      send(8'h12, 1'b1);
      tick(2);
      check("t6_data", 32'(data), 32'h12);
      check("t6_rises", n_rise - s_rise, 1);
      check("t6_latency", last_rise, exp_rise(t_start));
      check("t6_flags", (n_ferr - s_ferr) + (n_ovr - s_ovr), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
